// File: rtl/modadd_pkg.sv
// Shared definitions for the pipelined modular adder: configuration record,
// pipeline latency and construction of the special-form modulus.
package modadd_pkg;

  localparam int MODADD_MAXW = 128;

  typedef struct packed {
    int unsigned LOGQ;
    int unsigned LOGQH;
    int unsigned FF_IN;
    int unsigned FF_ADD;
    int unsigned FF_OUT;
  } modadd_params_t;

  function automatic int modadd_lat(input modadd_params_t p);
    return int'(p.FF_IN + p.FF_ADD + p.FF_OUT);
  endfunction

  // q = {qH, (LOGQ-LOGQH-1) zeros, 1}; caller truncates to LOGQ bits
  function automatic logic [MODADD_MAXW-1:0] modadd_q(input logic [MODADD_MAXW-1:0] qh,
                                                       input int unsigned logq,
                                                       input int unsigned logqh);
    return (qh << (logq - logqh)) | MODADD_MAXW'(1);
  endfunction

endpackage

// File: rtl/modadd_core.sv
// Combinational (A + B) mod q for operands already reduced below q.
module modadd_core
  import modadd_pkg::*;
#(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47
) (
  input  logic [LOGQ-1:0]  i_a,
  input  logic [LOGQ-1:0]  i_b,
  input  logic [LOGQH-1:0] i_qh,
  output logic [LOGQ-1:0]  o_c
);

  logic [LOGQ-1:0] w_q;
  logic [LOGQ:0]   w_s;
  logic [LOGQ+1:0] w_d;
  logic [LOGQ+1:0] w_mux;

  assign w_q = LOGQ'(modadd_q(MODADD_MAXW'(i_qh), LOGQ, LOGQH));
  assign w_s = {1'b0, i_a} + {1'b0, i_b};
  assign w_d = {1'b0, w_s} - {2'b00, w_q};
  // negative difference means the sum was already below q
  assign w_mux = w_d[LOGQ+1] ? {1'b0, w_s} : w_d;
  assign o_c   = LOGQ'(w_mux);

endmodule

// File: rtl/modadd_pipe.sv
// Pipelined modular adder with valid/ready stream, global stall, idle-only
// modulus load and busy flag. Each optional stage is either a register or a wire.
module modadd_pipe
  import modadd_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter int FF_IN  = 1,
  parameter int FF_ADD = 1,
  parameter int FF_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_load,
  input  logic [LOGQH-1:0] qH,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQ-1:0]  B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  C
);

  logic [LOGQH-1:0] r_qreg;
  logic             w_en, w_acc, w_load;
  logic [LOGQ-1:0]  w_a1, w_b1, w_c_core, w_c2, w_c3;
  logic             w_v1, w_v2, w_v3;
  logic             w_bsy_in, w_bsy_add, w_bsy_out;

  assign w_en      = ~out_valid | out_ready;
  assign w_acc     = in_valid & w_en;
  assign in_ready  = w_en;
  assign busy      = w_bsy_in | w_bsy_add | w_bsy_out;
  // a load is only safe when no beat can observe the modulus change
  assign w_load    = q_load & ~busy & ~w_acc;

  always_ff @(posedge clk) begin
    if (rst)         r_qreg <= '0;
    else if (w_load) r_qreg <= qH;
  end

  if (FF_IN != 0) begin : g_in_ff
    logic [LOGQ-1:0] r_a, r_b;
    logic            r_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_a <= '0;
        r_b <= '0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_a <= A;
        r_b <= B;
        r_v <= w_acc;
      end
    end
    assign w_a1     = r_a;
    assign w_b1     = r_b;
    assign w_v1     = r_v;
    assign w_bsy_in = r_v;
  end else begin : g_in_wire
    assign w_a1     = A;
    assign w_b1     = B;
    assign w_v1     = w_acc;
    assign w_bsy_in = 1'b0;
  end

  modadd_core #(.LOGQ(LOGQ), .LOGQH(LOGQH)) u_core (
    .i_a  (w_a1),
    .i_b  (w_b1),
    .i_qh (r_qreg),
    .o_c  (w_c_core)
  );

  if (FF_ADD != 0) begin : g_add_ff
    logic [LOGQ-1:0] r_c;
    logic            r_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_c <= '0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_c <= w_c_core;
        r_v <= w_v1;
      end
    end
    assign w_c2      = r_c;
    assign w_v2      = r_v;
    assign w_bsy_add = r_v;
  end else begin : g_add_wire
    assign w_c2      = w_c_core;
    assign w_v2      = w_v1;
    assign w_bsy_add = 1'b0;
  end

  if (FF_OUT != 0) begin : g_out_ff
    logic [LOGQ-1:0] r_c;
    logic            r_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_c <= '0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_c <= w_c2;
        r_v <= w_v2;
      end
    end
    assign w_c3      = r_c;
    assign w_v3      = r_v;
    assign w_bsy_out = r_v;
  end else begin : g_out_wire
    assign w_c3      = w_c2;
    assign w_v3      = w_v2;
    assign w_bsy_out = 1'b0;
  end

  assign C         = w_c3;
  assign out_valid = w_v3;

endmodule

// File: tb/tb_modadd_pipe.sv
// Bench for modadd_pipe: all seven stage configurations share one stimulus stream;
// each has a queue-based reference of (A+B)%q; configuration 7 gets directed checks.
module tb_modadd_pipe;
  import modadd_pkg::*;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] exp; } vec_t;
  typedef struct { logic [7:0] c; int t; } exp_t;

  logic       clk = 1'b0, rst = 1'b1, q_load = 1'b0, i_val = 1'b0, o_rdy = 1'b1;
  logic [4:0] qh = '0;
  logic [7:0] a = '0, b = '0;
  logic       ov [1:7];
  logic       ir [1:7];
  logic       bz [1:7];
  logic [7:0] cc [1:7];
  int         n_cmp = 0, n_err = 0, cyc = 0, q_ref = 249;
  bit         mon_on = 0, lat_chk = 1;
  event       done;
  vec_t       tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endfunction

  function automatic bit all_idle();
    for (int g = 1; g < 8; g++) if (bz[g] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar g = 1; g < 8; g++) begin : g_dut
    localparam modadd_params_t P = '{LOGQ: 8, LOGQH: 5, FF_IN: (g >> 2) & 1,
                                     FF_ADD: (g >> 1) & 1, FF_OUT: g & 1};
    localparam int L = modadd_lat(P);
    exp_t q_exp [$];

    modadd_pipe #(.LOGQ(8), .LOGQH(5), .FF_IN((g >> 2) & 1), .FF_ADD((g >> 1) & 1),
                  .FF_OUT(g & 1)) u_dut (
      .clk(clk), .rst(rst), .q_load(q_load), .qH(qh), .busy(bz[g]),
      .in_valid(i_val), .in_ready(ir[g]), .A(a), .B(b),
      .out_valid(ov[g]), .out_ready(o_rdy), .C(cc[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
        if (ov[g] && o_rdy) begin
          if (q_exp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL cfg%0d_spurious: got C=%0d with nothing outstanding, required no output", g, cc[g]);
          end else begin
            e = q_exp.pop_front();
            chk($sformatf("cfg%0d_c", g), 64'(cc[g]), 64'(e.c));
            if (lat_chk) chk($sformatf("cfg%0d_latency", g), 64'(cyc), 64'(e.t + L - 1));
          end
        end
        if (rst) q_exp.delete();
        else if (i_val && ir[g])
          q_exp.push_back('{c: 8'((int'(a) + int'(b)) % q_ref), t: cyc + 1});
      end
    end

    always @(done) chk($sformatf("cfg%0d_drained", g), 64'(q_exp.size()), 64'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!all_idle() && k < 40) begin
      step();
      k++;
    end
    chk({nm, "_idle"}, 64'(all_idle()), 64'(1));
  endtask

  task automatic load_q(input logic [4:0] v);
    q_load = 1'b1;
    qh     = v;
    step();
    q_load = 1'b0;
  endtask

  initial begin
    int got, first, sent;
    logic [7:0] c_hold;
    bit held;

    tbl[0] = '{a: 8'd100, b: 8'd149, exp: 8'd0};
    tbl[1] = '{a: 8'd248, b: 8'd248, exp: 8'd247};
    tbl[2] = '{a: 8'd0,   b: 8'd0,   exp: 8'd0};
    tbl[3] = '{a: 8'd248, b: 8'd0,   exp: 8'd248};

    // reset state
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", 64'(ov[7]), 64'(0));
    chk("rst_busy", 64'(bz[7]), 64'(0));
    chk("rst_c", 64'(cc[7]), 64'(0));
    chk("rst_in_ready", 64'(ir[7]), 64'(1));
    chk("rst_qreg", 64'(g_dut[7].u_dut.r_qreg), 64'(0));
    step();
    rst    = 1'b0;
    mon_on = 1'b1;

    // load and basic add
    load_q(5'b11111);
    q_ref = 249;
    a = 200; b = 100; i_val = 1'b1;
    step();
    i_val = 1'b0;
    @(negedge clk);
    chk("basic_busy", 64'(bz[7]), 64'(1));
    got = 0;
    while (!ov[7] && got < 10) begin
      @(negedge clk);
      got++;
    end
    chk("basic_latency", 64'(got), 64'(2));
    chk("basic_c", 64'(cc[7]), 64'(51));
    @(negedge clk);
    chk("basic_drain_valid", 64'(ov[7]), 64'(0));
    chk("basic_drain_busy", 64'(bz[7]), 64'(0));
    step();

    // wrap boundaries, back to back
    got = 0;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      i_val = (k < 4);
      if (k < 4) begin
        a = tbl[k].a;
        b = tbl[k].b;
      end
      @(negedge clk);
      if (ov[7]) begin
        if (got < 4) chk($sformatf("wrap_c%0d", got), 64'(cc[7]), 64'(tbl[got].exp));
        if (first < 0) first = k;
        chk("wrap_consecutive", 64'(k - first), 64'(got));
        got++;
      end
      step();
    end
    chk("wrap_count", 64'(got), 64'(4));
    wait_idle("wrap");

    // backpressure
    lat_chk = 0;
    got = 0; sent = 0; held = 0; c_hold = '0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      o_rdy = !(k >= 3 && k < 6);
      i_val = (sent < 5);
      a     = 8'(sent + 1);
      b     = 8'(10 * (sent + 1));
      @(negedge clk);
      if (ov[7] && !o_rdy) begin
        chk("bp_in_ready", 64'(ir[7]), 64'(0));
        if (held) chk("bp_c_hold", 64'(cc[7]), 64'(c_hold));
        c_hold = cc[7];
        held   = 1;
      end else held = 0;
      if (ov[7] && o_rdy) begin
        chk($sformatf("bp_c%0d", got), 64'(cc[7]), 64'(11 * (got + 1)));
        got++;
      end
      if (i_val && ir[7]) sent++;
      step();
    end
    i_val = 1'b0;
    o_rdy = 1'b1;
    chk("bp_count", 64'(got), 64'(5));
    wait_idle("bp");
    lat_chk = 1;

    // load while busy is ignored
    a = 200; b = 100; i_val = 1'b1;
    step();
    i_val = 1'b0;
    load_q(5'b10000);
    qh = 5'b11111;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov[7]) begin
        chk("lwb_c", 64'(cc[7]), 64'(51));
        got++;
      end
      step();
    end
    chk("lwb_count", 64'(got), 64'(1));
    wait_idle("lwb");

    // load together with an accepted beat is ignored
    a = 100; b = 100; i_val = 1'b1; q_load = 1'b1; qh = 5'b10000;
    step();
    q_load = 1'b0;
    step();
    i_val = 1'b0;
    wait_idle("ldbeat");

    // load at idle takes effect
    load_q(5'b10000);
    q_ref = 129;
    a = 100; b = 100; i_val = 1'b1;
    step();
    i_val = 1'b0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov[7]) begin
        chk("idle_load_c", 64'(cc[7]), 64'(71));
        got++;
      end
      step();
    end
    chk("idle_load_count", 64'(got), 64'(1));
    load_q(5'b11111);
    q_ref = 249;

    // reset mid-stream
    a = 10; b = 20; i_val = 1'b1;
    step();
    a = 30; b = 40;
    step();
    i_val = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(ov[7]), 64'(0));
    chk("midrst_busy", 64'(all_idle()), 64'(1));
    chk("midrst_qreg", 64'(g_dut[7].u_dut.r_qreg), 64'(0));
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("midrst_no_stale", 64'(ov[7]), 64'(0));
    end
    step();
    load_q(5'b11111);

    // random sweep, free-flowing sink: latency checked per configuration
    for (int k = 0; k < 300; k++) begin
      i_val = ($urandom_range(0, 3) != 0);
      a     = 8'($urandom_range(0, 248));
      b     = 8'($urandom_range(0, 248));
      step();
    end
    i_val = 1'b0;
    wait_idle("sweep");

    // random sweep with a stalling sink
    lat_chk = 0;
    for (int k = 0; k < 300; k++) begin
      i_val = ($urandom_range(0, 3) != 0);
      o_rdy = ($urandom_range(0, 2) != 0);
      a     = 8'($urandom_range(0, 248));
      b     = 8'($urandom_range(0, 248));
      step();
    end
    i_val = 1'b0;
    o_rdy = 1'b1;
    wait_idle("stall_sweep");
    step();

    ->done;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/modadd_pipe.md
Name: modadd_pipe

Overview:
- Pipelined modular adder, the additive counterpart of the codebase's modular subtractor.
- Computes C = (A + B) mod q with the same special-form modulus q = {qH, (W-1) zeros, 1}, W = LOGQ-LOGQH.
- Unlike the subtractor, it has a valid/ready stream interface with global-stall backpressure, a modulus register that is loaded only when the pipeline is idle, and a busy indicator.
- It feeds NTT butterfly and accumulator datapaths.

Parameters:
- LOGQ, 64, modulus/operand/result width in bits.
- LOGQH, 47, width of the qH high part; 1 <= LOGQH < LOGQ.
- FF_IN, 1, register stage on A/B (0 or 1).
- FF_ADD, 1, register stage after the sum / sum-minus-q computation (0 or 1).
- FF_OUT, 1, register stage on C. Must be 1 whenever FF_IN=FF_ADD=0, so that LAT >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- q_load  in  1  load qH into the modulus register.
- qH  in  LOGQH  high part of the modulus.
- busy  out  1  high while any pipeline stage holds a valid entry.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid & in_ready.
- A  in  LOGQ  operand, required < q.
- B  in  LOGQ  operand, required < q.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- C  out  LOGQ  (A+B) mod q.

Behaviour:
- One clock; reset is synchronous and active-high. On a clk edge with rst=1:
  - all stage valid bits clear, so out_valid=0 and busy=0;
  - the modulus register clears to 0;
  - C data registers are don't-care, but the bench must see C=0 after reset, so data registers also reset to 0.
- Modulus:
  - qreg <= qH on a clk edge when q_load=1 and busy=0 and no beat is accepted in that cycle.
  - A q_load while busy=1 or while a beat is accepted is ignored (no queuing).
  - q = {qreg, (W-1)'b0, 1'b1}.
  - All in-flight beats use the qreg value present when they compute their stage; this is why loads are restricted to idle.
- Arithmetic, per beat:
  - S = A + B, LOGQ+1 bits.
  - D = S - q, LOGQ+2 bits signed.
  - C = D[LOGQ+1] ? S[LOGQ-1:0] : D[LOGQ-1:0].
  - S == q gives C=0.
  - If operands are >= q the result is unspecified, but this must not disturb the handshake.
- Pipeline:
  - LAT = FF_IN+FF_ADD+FF_OUT stages.
  - Each stage carries data plus a valid bit.
  - Global enable en = ~out_valid | out_ready.
  - All stages advance only when en=1. On advance, stage k takes stage k-1 and stage 0 takes (in_valid & in_ready).
  - in_ready = en (combinational from out_ready and the last-stage valid).
  - Disabled stages (FF_x=0) are wires; a disabled stage carries no valid bit.
  - Latency: a beat accepted at edge t appears with out_valid=1 after edge t+LAT-1. C is the stage-LAT register output, i.e. visible in the cycle after the last capture.
  - Throughput: one beat per cycle when out_ready stays 1.
- Backpressure:
  - While out_valid=1 and out_ready=0, all stages hold, C and out_valid remain stable, and in_ready=0.
  - Bubbles are not compressed.
- busy = OR of all stage valid bits.
- Simultaneous events:
  - q_load together with an in_valid beat in the same cycle when busy=0: the beat is accepted and the load is ignored.
  - rst with any other input: reset wins.
  - Reset mid-stream: all in-flight beats are dropped; out_valid falls on the reset edge.

Decomposition:
- The shared package modadd_pkg (sibling of the subtractor's header) holds:
  - the modadd_params_t struct {LOGQ, LOGQH, FF_IN, FF_ADD, FF_OUT};
  - the function modadd_lat(params) returning LAT;
  - the function modadd_q(qH) building q.
- One sub-module, modadd_core: purely combinational S/D/select with LOGQ/LOGQH parameters, instantiated between the registered stages. modadd_pipe owns the valid chain, stall, modulus register and busy.

Test Plan:
- Configuration for all scenarios: LOGQ=8, LOGQH=5, all FF=1, qH=5'b11111, so q=249.
- Load and basic add: load qH at idle, then A=200, B=100, out_ready=1 -> three edges later out_valid=1, C=51; busy low one cycle after drain.
- Wrap boundaries, back-to-back beats: (100,149) -> 0; (248,248) -> 247; (0,0) -> 0; (248,0) -> 248. Results arrive in order on consecutive cycles.
- Backpressure: stream 5 beats (i, 10*i) with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, C held stable, no beat lost or duplicated, order preserved.
- Load while busy: q_load with qH=5'b10000 (q=129) while a beat is in flight -> ignored, beat (200,100) still gives 51. A load at idle then takes effect: (100,100) -> 71.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and busy=0 on the next cycle, qreg=0, no stale result appears afterwards.
- Parameter sweep: FF_IN/FF_ADD/FF_OUT in {0,1}^3 excluding all-zero -> latency equals modadd_lat and the random results match a reference (A+B)%q.
